// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target fronting an 8-bit register file with auto-incrementing pointer
module i2c_slave_regs #(
    parameter int SYNC_STAGES = 2,
    parameter bit AUTO_INC    = 1'b1
) (
    input  logic       hclk,
    input  logic       hreset,
    input  logic [6:0] slave_addr,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_A_ACK, S_PTR, S_P_ACK, S_WR, S_W_ACK, S_RD, S_M_ACK, S_WAIT_P
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_p_q, scl_p_d;
    logic                   sda_p_q, sda_p_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic [6:0]             own_q, own_d;
    logic                   sda_oe_q, sda_oe_d;
    logic [7:0]             reg_addr_q, reg_addr_d;
    logic [7:0]             reg_wdata_q, reg_wdata_d;
    logic                   reg_we_q, reg_we_d;
    logic                   reg_re_q, reg_re_d;
    logic                   busy_q, busy_d;

    logic       scl_s, sda_s;
    logic       rise, fall, start_ev, stop_ev;
    logic [7:0] byte_in;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign rise     = scl_s & ~scl_p_q;
    assign fall     = ~scl_s & scl_p_q;
    assign start_ev = scl_s & scl_p_q & sda_p_q & ~sda_s;
    assign stop_ev  = scl_s & scl_p_q & ~sda_p_q & sda_s;
    assign byte_in  = {shreg_q[6:0], sda_s};

    assign sda_out   = 1'b0;
    assign sda_oe    = sda_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;

    // Bus event decode, protocol FSM, pointer and strobe generation
    always_comb begin
        state_d     = state_q;
        scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_p_d     = scl_s;
        sda_p_d     = sda_s;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        own_d       = own_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        busy_d      = busy_q;

        // Pointer moves one cycle after the strobe so the strobe sees the old address
        if (AUTO_INC && (reg_we_q || reg_re_q)) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end

        if (stop_ev) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_ev) begin
            state_d  = S_ADDR;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            own_d    = slave_addr;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (rise) begin
                        shreg_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (shreg_q[6:0] == own_q) begin
                                state_d = S_A_ACK;
                                rw_d    = sda_s;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                S_A_ACK: begin
                    // sda_oe_q distinguishes the fall that opens the ACK slot from the one closing it
                    if (rise && rw_q && sda_oe_q) begin
                        reg_re_d = 1'b1;
                    end
                    if (fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            cnt_d = 3'd0;
                            if (rw_q) begin
                                shreg_d  = reg_rdata;
                                sda_oe_d = ~reg_rdata[7];
                                state_d  = S_RD;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = S_PTR;
                            end
                        end
                    end
                end
                S_PTR, S_WR: begin
                    if (rise) begin
                        shreg_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (state_q == S_PTR) begin
                                reg_addr_d = byte_in;
                                state_d    = S_P_ACK;
                            end else begin
                                reg_wdata_d = byte_in;
                                reg_we_d    = 1'b1;
                                state_d     = S_W_ACK;
                            end
                        end
                    end
                end
                S_P_ACK, S_W_ACK: begin
                    if (fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            state_d  = S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (fall) begin
                        if (cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            state_d  = S_M_ACK;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            sda_oe_d = ~shreg_q[6];
                            cnt_d    = cnt_q + 3'd1;
                        end
                    end
                end
                S_M_ACK: begin
                    if (rise) begin
                        if (!sda_s) begin
                            reg_re_d = 1'b1;
                        end else begin
                            state_d = S_WAIT_P;
                        end
                    end else if (fall) begin
                        shreg_d  = reg_rdata;
                        sda_oe_d = ~reg_rdata[7];
                        cnt_d    = 3'd0;
                        state_d  = S_RD;
                    end
                end
                S_IDLE, S_WAIT_P: begin
                end
                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State register; synchronisers reset to the idle-high bus level
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= S_IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_p_q     <= 1'b1;
            sda_p_q     <= 1'b1;
            shreg_q     <= 8'h00;
            cnt_q       <= 3'd0;
            rw_q        <= 1'b0;
            own_q       <= 7'h00;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_p_q     <= scl_p_d;
            sda_p_q     <= sda_p_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            own_q       <= own_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - bus-level master model, register file and checks for i2c_slave_regs
module tb_i2c_slave_regs;

    localparam int Q = 10;

    logic       hclk = 1'b0;
    logic       hreset = 1'b1;
    logic [6:0] slave_addr = 7'h50;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_out, sda_oe, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] rdata_q;
    logic       sda_line;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regs dut (
        .hclk(hclk), .hreset(hreset), .slave_addr(slave_addr), .scl(scl), .sda_in(sda_line),
        .sda_out(sda_out), .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(rdata_q), .busy(busy)
    );

    always #5 hclk = ~hclk;

    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    logic [7:0] we_addr_q [$];
    logic [7:0] we_data_q [$];
    logic [7:0] re_addr_q [$];
    int  both_cnt = 0, oe_conflict = 0, oe_watch_cnt = 0;
    bit  mbit = 1'b0, watch = 1'b0, init_mem = 1'b0;
    int  n_chk = 0, n_fail = 0;

    // Register file behind the target plus strobe/drive monitors
    always @(posedge hclk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= exp_mem[i];
        end
        if (reg_we) begin
            mem[reg_addr] <= reg_wdata;
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (reg_re) begin
            rdata_q <= mem[reg_addr];
            re_addr_q.push_back(reg_addr);
        end
        if (reg_we && reg_re) both_cnt++;
        if (mbit && sda_oe) oe_conflict++;
        if (watch && sda_oe) oe_watch_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hw(input int n);
        repeat (n) @(negedge hclk);
    endtask

    task automatic i2c_start();
        if (!scl) begin
            sda_m = 1'b1; hw(Q); scl = 1'b1; hw(Q);
        end
        sda_m = 1'b0; hw(Q); scl = 1'b0; hw(2);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; hw(Q); scl = 1'b1; hw(Q); sda_m = 1'b1; hw(Q);
    endtask

    task automatic clk_bit(input bit b, input bit master, output bit r);
        sda_m = b; hw(Q);
        scl = 1'b1; mbit = master; hw(Q);
        r = sda_line; mbit = 1'b0; scl = 1'b0; hw(2);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack);
        bit r;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b1, r);
        clk_bit(1'b1, 1'b0, ack);
    endtask

    task automatic recv_byte(input bit mack, output logic [7:0] d);
        bit r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, r);
            d[i] = r;
        end
        clk_bit(mack, 1'b1, r);
    endtask

    initial begin
        bit ack;
        logic [7:0] d, v0, v1;
        int wb, rb, ptr_m;

        for (int i = 0; i < 256; i++) exp_mem[i] = 8'($urandom);
        init_mem = 1'b1;
        hw(5);
        init_mem = 1'b0;
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_sda_out", sda_out, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_reg_re", reg_re, 0);
        chk("rst_busy", busy, 0);
        hreset = 1'b0;
        hw(5);
        ptr_m = 0;

        // Write transfer with auto-increment
        wb = we_addr_q.size();
        i2c_start();
        send_byte(8'hA0, ack); chk("t1_addr_ack", ack, 0);
        chk("t1_busy", busy, 1);
        send_byte(8'h10, ack); chk("t1_ptr_ack", ack, 0);
        send_byte(8'hAB, ack); chk("t1_d0_ack", ack, 0);
        send_byte(8'hCD, ack); chk("t1_d1_ack", ack, 0);
        i2c_stop(); hw(4);
        exp_mem[8'h10] = 8'hAB; exp_mem[8'h11] = 8'hCD; ptr_m = 8'h12;
        chk("t1_we_count", we_addr_q.size() - wb, 2);
        chk("t1_we0_addr", we_addr_q[wb], 8'h10);
        chk("t1_we0_data", we_data_q[wb], 8'hAB);
        chk("t1_we1_addr", we_addr_q[wb+1], 8'h11);
        chk("t1_we1_data", we_data_q[wb+1], 8'hCD);
        chk("t1_busy_after", busy, 0);
        chk("t1_ptr", reg_addr, ptr_m);

        // Pointer set, RESTART, read three bytes (ACK, ACK, NACK)
        rb = re_addr_q.size();
        i2c_start();
        send_byte(8'hA0, ack); chk("t2_addr_ack", ack, 0);
        send_byte(8'h20, ack); chk("t2_ptr_ack", ack, 0);
        ptr_m = 8'h20;
        i2c_start();
        send_byte(8'hA1, ack); chk("t2_sar_ack", ack, 0);
        for (int k = 0; k < 3; k++) begin
            recv_byte(k == 2, d);
            chk($sformatf("t2_rd%0d", k), d, exp_mem[ptr_m]);
            ptr_m = (ptr_m + 1) % 256;
        end
        hw(4);
        chk("t2_released", sda_oe, 0);
        i2c_stop(); hw(4);
        chk("t2_re_count", re_addr_q.size() - rb, 3);
        for (int k = 0; k < 3; k++) chk($sformatf("t2_re%0d_addr", k), re_addr_q[rb+k], 8'h20 + k);
        chk("t2_ptr", reg_addr, ptr_m);

        // Address mismatch: never drive, no strobes
        wb = we_addr_q.size(); rb = re_addr_q.size();
        watch = 1'b1;
        i2c_start();
        send_byte(8'hA2, ack); chk("t3_addr_nack", ack, 1);
        send_byte(8'($urandom), ack); chk("t3_data_nack", ack, 1);
        i2c_stop(); hw(4);
        watch = 1'b0;
        chk("t3_oe_seen", oe_watch_cnt, 0);
        chk("t3_no_we", we_addr_q.size() - wb, 0);
        chk("t3_no_re", re_addr_q.size() - rb, 0);
        chk("t3_busy", busy, 0);
        chk("t3_ptr", reg_addr, ptr_m);

        // Pointer wrap 0xFF -> 0x00
        wb = we_addr_q.size();
        v0 = 8'($urandom); v1 = 8'($urandom);
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'hFF, ack);
        send_byte(v0, ack); chk("t4_d0_ack", ack, 0);
        send_byte(v1, ack); chk("t4_d1_ack", ack, 0);
        i2c_stop(); hw(4);
        exp_mem[8'hFF] = v0; exp_mem[8'h00] = v1; ptr_m = 1;
        chk("t4_we_count", we_addr_q.size() - wb, 2);
        chk("t4_we0_addr", we_addr_q[wb], 8'hFF);
        chk("t4_we0_data", we_data_q[wb], v0);
        chk("t4_we1_addr", we_addr_q[wb+1], 8'h00);
        chk("t4_we1_data", we_data_q[wb+1], v1);
        chk("t4_ptr", reg_addr, ptr_m);

        // Abort a data byte with STOP, then read from the persisted pointer
        wb = we_addr_q.size(); rb = re_addr_q.size();
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack); chk("t5_ptr_ack", ack, 0);
        for (int k = 0; k < 3; k++) clk_bit(1'($urandom), 1'b1, ack);
        i2c_stop(); hw(4);
        chk("t5_no_we", we_addr_q.size() - wb, 0);
        chk("t5_busy", busy, 0);
        i2c_start();
        send_byte(8'hA1, ack); chk("t5_sar_ack", ack, 0);
        recv_byte(1'b1, d);
        chk("t5_rd", d, exp_mem[8'h05]);
        i2c_stop(); hw(4);
        chk("t5_re_count", re_addr_q.size() - rb, 1);
        chk("t5_re_addr", re_addr_q[rb], 8'h05);
        chk("t5_ptr", reg_addr, 8'h06);

        // Reset while the target drives a 0 data bit
        v0 = 8'($urandom) & 8'h7F;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h30, ack);
        send_byte(v0, ack);
        i2c_stop();
        exp_mem[8'h30] = v0;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h30, ack);
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, ack); chk("t6_sar_ack", ack, 0);
        hw(4);
        chk("t6_driving", sda_oe, 1);
        hreset = 1'b1;
        @(posedge hclk); #1;
        chk("t6_rst_sda_oe", sda_oe, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_reg_addr", reg_addr, 0);
        chk("t6_rst_reg_wdata", reg_wdata, 0);
        chk("t6_rst_strobes", {reg_we, reg_re}, 0);
        hw(2);
        hreset = 1'b0;
        hw(4);
        i2c_stop();
        rb = re_addr_q.size();
        i2c_start();
        send_byte(8'hA1, ack); chk("t6_after_ack", ack, 0);
        recv_byte(1'b1, d);
        chk("t6_after_rd", d, exp_mem[8'h00]);
        i2c_stop(); hw(4);
        chk("t6_re_addr", re_addr_q.size() > rb ? re_addr_q[rb] : 8'hxx, 8'h00);

        chk("both_strobes", both_cnt, 0);
        chk("drive_conflict", oe_conflict, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
